m_clock_display: RTL

Display stage downstream of the seconds timer. Consumes the timer's one-hot 10-bit seconds digit, extends it to an MM:SS count by detecting 9→0 wrap-arounds, and drives a 4-digit multiplexed 7-segment display. It scans the digits with its own prescaler and flags malformed one-hot input.

---
 rtl/m_clock_display_pkg.sv | 57 +++++
 rtl/m_seg7_decode.sv | 27 ++
 rtl/m_clock_display.sv | 128 ++++++++++++
 3 files changed

// File: rtl/m_clock_display_pkg.sv
// Shared constants, digit-index encoding and one-hot helpers for the MM:SS
// multiplexed 7-segment display stage.
package m_clock_display_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    localparam logic [3:0] DIG_MAX9 = 4'd9;
    localparam logic [3:0] DIG_MAX5 = 4'd5;

    typedef enum logic [1:0] {
        DIG_S1  = 2'd0,
        DIG_S10 = 2'd1,
        DIG_M1  = 2'd2,
        DIG_M10 = 2'd3
    } dig_idx_e;

    function automatic logic is_one_hot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // Lowest set bit wins; the result only matters when the input is one-hot.
    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (v[k]) begin
                r = 4'(k);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] dig_onehot(input dig_idx_e i);
        logic [3:0] r;
        case (i)
            DIG_S1:  r = 4'b0001;
            DIG_S10: r = 4'b0010;
            DIG_M1:  r = 4'b0100;
            DIG_M10: r = 4'b1000;
            default: r = 4'b0001;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m_seg7_decode.sv
// Purely combinational BCD to 7-segment pattern (g..a, active-high).
module m_seg7_decode
    import m_clock_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    // Pattern lookup; anything outside 0-9 shows a dash.
    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/m_clock_display.sv
// Extends the timer's one-hot seconds digit to an MM:SS count and scans it
// onto a 4-digit multiplexed 7-segment display.
module m_clock_display
    import m_clock_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sec,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       sec_err
);

    localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  SCNT_LAST = CW'(SCAN_DIV - 1);

    logic [3:0]    s1_s;
    logic          sec_valid_s;
    logic          wrap_s;
    logic [3:0]    s1_q_r, s10_r, m1_r, m10_r;
    logic [3:0]    s10_nxt_s, m1_nxt_s, m10_nxt_s;
    logic [CW-1:0] scnt_r, scnt_nxt_s;
    dig_idx_e      idx_r, idx_nxt_s;
    logic [3:0]    digit_sel_s;
    logic [6:0]    pattern_s;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          sec_err_r;

    // One-hot decode, validity and 9->0 wrap detection.
    always_comb begin
        s1_s        = onehot_to_bcd(sec);
        sec_valid_s = is_one_hot(sec);
        wrap_s      = sec_valid_s && (s1_q_r == DIG_MAX9) && (s1_s == 4'd0);
    end

    // Carry chain: the whole ripple settles within the wrap cycle.
    always_comb begin
        s10_nxt_s = s10_r;
        m1_nxt_s  = m1_r;
        m10_nxt_s = m10_r;
        if (wrap_s) begin
            if (s10_r == DIG_MAX5) begin
                s10_nxt_s = 4'd0;
                if (m1_r == DIG_MAX9) begin
                    m1_nxt_s = 4'd0;
                    if (m10_r == DIG_MAX5) begin
                        m10_nxt_s = 4'd0;
                    end else begin
                        m10_nxt_s = m10_r + 4'd1;
                    end
                end else begin
                    m1_nxt_s = m1_r + 4'd1;
                end
            end else begin
                s10_nxt_s = s10_r + 4'd1;
            end
        end else begin
            s10_nxt_s = s10_r;
        end
    end

    // Scan prescaler and digit index; an/seg follow the next index so they
    // switch on the same edge as idx and each slot lasts exactly SCAN_DIV.
    always_comb begin
        scnt_nxt_s = scnt_r;
        idx_nxt_s  = idx_r;
        if (scnt_r == SCNT_LAST) begin
            scnt_nxt_s = {CW{1'b0}};
            idx_nxt_s  = dig_idx_e'(2'(idx_r + 2'd1));
        end else begin
            scnt_nxt_s = scnt_r + CW'(1);
        end
    end

    // Digit selection for the segment decoder.
    always_comb begin
        digit_sel_s = s1_q_r;
        case (idx_nxt_s)
            DIG_S1:  digit_sel_s = s1_q_r;
            DIG_S10: digit_sel_s = s10_r;
            DIG_M1:  digit_sel_s = m1_r;
            DIG_M10: digit_sel_s = m10_r;
            default: digit_sel_s = s1_q_r;
        endcase
    end

    m_seg7_decode u_seg7 (
        .bcd     (digit_sel_s),
        .pattern (pattern_s)
    );

    // Counter, scan and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q_r    <= 4'd0;
            s10_r     <= 4'd0;
            m1_r      <= 4'd0;
            m10_r     <= 4'd0;
            scnt_r    <= {CW{1'b0}};
            idx_r     <= DIG_S1;
            an_r      <= 4'b0001;
            seg_r     <= SEG_0;
            sec_err_r <= 1'b0;
        end else begin
            if (sec_valid_s) begin
                s1_q_r <= s1_s;
            end else begin
                s1_q_r <= s1_q_r;
            end
            s10_r     <= s10_nxt_s;
            m1_r      <= m1_nxt_s;
            m10_r     <= m10_nxt_s;
            scnt_r    <= scnt_nxt_s;
            idx_r     <= idx_nxt_s;
            an_r      <= dig_onehot(idx_nxt_s);
            seg_r     <= pattern_s;
            sec_err_r <= ~sec_valid_s;
        end
    end

    assign seg     = seg_r;
    assign an      = an_r;
    assign sec_err = sec_err_r;

endmodule
